// File: rtl/sca_blk_sched.sv
// SCA block scheduler for one CFEB: allocates write blocks on LCT, queues frozen blocks, sequences digitization.
// Optional SCA_LCT_EDGE_EN turns LCT into a rising-edge request; undefined means one request per high cycle.
module sca_blk_sched #(
  parameter int unsigned DIG_TMO = 256,
  parameter int unsigned OVF_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_lct,
  output logic [3:0]       o_wblk,
  output logic             o_full,
  output logic [3:0]       o_nfree,
  output logic [15:0]      o_busy_map,
  output logic             o_dig_req,
  output logic [3:0]       o_dig_blk,
  input  logic             i_dig_ack,
  input  logic             i_dig_done,
  output logic [OVF_W-1:0] o_ovf_cnt,
  output logic             o_tmo_err,
  input  logic             i_clr_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_REL} state_t;

  localparam logic [OVF_W-1:0] OVF_ONE = {{(OVF_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]      TMO_LAST = 16'(DIG_TMO - 1);

  logic [3:0]       r_wblk;
  logic [15:0]      r_busy_map;
  logic [3:0]       r_nfree;
  logic             r_full;
  logic [OVF_W-1:0] r_ovf_cnt;
  logic             r_tmo_err;
  logic [3:0]       r_q_mem [16];
  logic [3:0]       r_q_wr;
  logic [3:0]       r_q_rd;
  logic [4:0]       r_q_cnt;
  state_t           r_state;
  logic             r_dig_req;
  logic [3:0]       r_dig_blk;
  logic [15:0]      r_timer;

  logic             w_lct_req;
  logic             w_alloc;
  logic             w_drop;
  logic             w_rel;
  logic [3:0]       w_free_idx;
  logic [3:0]       w_nfree_nxt;
  state_t           w_state_nxt;
  logic             w_dig_req_nxt;
  logic [3:0]       w_dig_blk_nxt;
  logic [15:0]      w_timer_nxt;
  logic             w_tmo_set;

`ifdef SCA_LCT_EDGE_EN
  logic r_lct_d;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lct_d <= 1'b0;
    else       r_lct_d <= i_lct;
  end
  assign w_lct_req = i_lct & ~r_lct_d;
`else
  assign w_lct_req = i_lct;
`endif

  assign w_alloc     = w_lct_req && (r_nfree != 4'd0);
  assign w_drop      = w_lct_req && (r_nfree == 4'd0);
  assign w_rel       = (r_state == S_REL);
  assign w_nfree_nxt = r_nfree - {3'b000, w_alloc} + {3'b000, w_rel};

  // Scan downward so the lowest-index free block wins.
  always_comb begin
    w_free_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!r_busy_map[i]) w_free_idx = i[3:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wblk     <= 4'd0;
      r_busy_map <= 16'h0001;
      r_nfree    <= 4'd15;
      r_full     <= 1'b0;
    end else begin
      if (w_alloc) r_wblk <= w_free_idx;
      r_busy_map <= (r_busy_map | (w_alloc ? (16'h0001 << w_free_idx) : 16'h0000))
                    & ~(w_rel ? (16'h0001 << r_dig_blk) : 16'h0000);
      r_nfree    <= w_nfree_nxt;
      r_full     <= (w_nfree_nxt == 4'd0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_alloc) r_q_mem[r_q_wr] <= r_wblk;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q_wr  <= 4'd0;
      r_q_rd  <= 4'd0;
      r_q_cnt <= 5'd0;
    end else begin
      if (w_alloc) r_q_wr <= r_q_wr + 4'd1;
      if (w_rel)   r_q_rd <= r_q_rd + 4'd1;
      r_q_cnt <= r_q_cnt + {4'd0, w_alloc} - {4'd0, w_rel};
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dig_req_nxt = r_dig_req;
    w_dig_blk_nxt = r_dig_blk;
    w_timer_nxt   = r_timer;
    w_tmo_set     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_q_cnt != 5'd0) begin
          w_state_nxt   = S_REQ;
          w_dig_req_nxt = 1'b1;
          w_dig_blk_nxt = r_q_mem[r_q_rd];
        end
      end
      S_REQ: begin
        if (i_dig_ack) begin
          w_state_nxt   = S_BUSY;
          w_dig_req_nxt = 1'b0;
          w_timer_nxt   = 16'd0;
        end
      end
      S_BUSY: begin
        w_timer_nxt = r_timer + 16'd1;
        if (i_dig_done) begin
          w_state_nxt = S_REL;
        end else if (r_timer == TMO_LAST) begin
          w_state_nxt = S_REL;
          w_tmo_set   = 1'b1;
        end
      end
      S_REL:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_dig_req <= 1'b0;
      r_dig_blk <= 4'd0;
      r_timer   <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_dig_req <= w_dig_req_nxt;
      r_dig_blk <= w_dig_blk_nxt;
      r_timer   <= w_timer_nxt;
    end
  end

  // A set event in the same cycle as CLR_ERR takes precedence over the clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_drop) begin
        if (i_clr_err)       r_ovf_cnt <= OVF_ONE;
        else if (!(&r_ovf_cnt)) r_ovf_cnt <= r_ovf_cnt + OVF_ONE;
      end else if (i_clr_err) begin
        r_ovf_cnt <= '0;
      end
      if (w_tmo_set)      r_tmo_err <= 1'b1;
      else if (i_clr_err) r_tmo_err <= 1'b0;
    end
  end

  assign o_wblk     = r_wblk;
  assign o_busy_map = r_busy_map;
  assign o_nfree    = r_nfree;
  assign o_full     = r_full;
  assign o_dig_req  = r_dig_req;
  assign o_dig_blk  = r_dig_blk;
  assign o_ovf_cnt  = r_ovf_cnt;
  assign o_tmo_err  = r_tmo_err;

endmodule
